// File: rtl/iob_uart_fifo_core_pkg.sv
// Shared definitions for the iob_uart FIFO core: parity-mode encodings,
// FSM state encoding, sticky error bit indices and parity helpers.
package iob_uart_fifo_core_pkg;

    // Parity modes; 2'b00 and 2'b11 both mean "no parity bit".
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Bit positions inside the sticky error vector.
    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_OVERRUN = 2;

    // Common state encoding for the TX and RX frame FSMs.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // True when the selected mode carries a parity bit.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit for a frame; unused upper data bits must be zero.
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/iob_uart_fifo_core_sfifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// The head entry is read combinationally so data is valid in the same cycle
// as the not-empty indication. A push into a full FIFO is accepted only when
// a pop frees an entry in the same cycle.
module iob_uart_fifo_core_sfifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cke_i,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_pop;
    logic          w_push;

    assign empty_o = (r_level == '0);
    assign full_o  = (r_level == (AW+1)'(DEPTH));
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);
    assign data_o  = r_mem[r_rd_ptr];
    assign level_o = r_level;

    // Storage array: written on an accepted push, no reset needed.
    always_ff @(posedge clk_i) begin
        if (cke_i && w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (cke_i) begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/iob_uart_fifo_core.sv
// iob_uart FIFO core: TX/RX FIFOs, programmable frame format and sticky RX
// error flags between the CPU-side streams and the txd/rxd pads.
// Optional build macro IOB_UART_FLOW_CTRL_EN enables cts_i gating of TX frame
// starts and RX-occupancy-based rts_o; without it cts_i is ignored and rts_o
// simply follows rx_en_i one cycle later.
module iob_uart_fifo_core
    import iob_uart_fifo_core_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int RTS_MARGIN = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cke_i,
    input  logic                      soft_rst_i,
    input  logic                      tx_en_i,
    input  logic                      rx_en_i,
    input  logic [DIV_W-1:0]          div_i,
    input  logic [1:0]                parity_i,
    input  logic                      stop2_i,
    input  logic [DATA_W-1:0]         tx_data_i,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    output logic                      tx_idle_o,
    output logic [DATA_W-1:0]         rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic [$clog2(TX_DEPTH):0] tx_level_o,
    output logic [$clog2(RX_DEPTH):0] rx_level_o,
    output logic [2:0]                err_o,
    input  logic                      err_clr_i,
    input  logic                      rxd_i,
    output logic                      txd_o,
    input  logic                      cts_i,
    output logic                      rts_o
);
    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    logic w_rst;
    assign w_rst = rst_i | soft_rst_i;

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_tx_head;
    logic              w_tx_empty;
    logic              w_tx_full;
    logic              w_tx_launch;
    logic              w_rx_empty;
    logic              w_rx_full;
    logic              w_rx_done;
    logic [DATA_W-1:0] r_rx_shift;

    iob_uart_fifo_core_sfifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (w_rst),
        .cke_i   (cke_i),
        .push_i  (tx_valid_i),
        .data_i  (tx_data_i),
        .pop_i   (w_tx_launch),
        .data_o  (w_tx_head),
        .empty_o (w_tx_empty),
        .full_o  (w_tx_full),
        .level_o (tx_level_o)
    );

    iob_uart_fifo_core_sfifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (w_rst),
        .cke_i   (cke_i),
        .push_i  (w_rx_done),
        .data_i  (r_rx_shift),
        .pop_i   (rx_ready_i),
        .data_o  (rx_data_o),
        .empty_o (w_rx_empty),
        .full_o  (w_rx_full),
        .level_o (rx_level_o)
    );

    assign tx_ready_o = ~w_tx_full;
    assign rx_valid_o = ~w_rx_empty;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_cts_ok;
    logic w_rts_next;
    logic r_rts;

`ifdef IOB_UART_FLOW_CTRL_EN
    logic r_cts_s1;
    logic r_cts_s2;

    // Two-flop synchroniser for the asynchronous cts_i line.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_cts_s1 <= 1'b0;
            r_cts_s2 <= 1'b0;
        end else if (cke_i) begin
            r_cts_s1 <= cts_i;
            r_cts_s2 <= r_cts_s1;
        end
    end

    assign w_cts_ok   = r_cts_s2;
    assign w_rts_next = rx_en_i & ((RX_DEPTH - int'(rx_level_o)) > RTS_MARGIN);
`else
    logic w_unused_flow;
    assign w_unused_flow = cts_i | (RTS_MARGIN < 0);
    assign w_cts_ok      = 1'b1;
    assign w_rts_next    = rx_en_i;
`endif

    // Registered request-to-send.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_rts <= 1'b0;
        end else if (cke_i) begin
            r_rts <= w_rts_next;
        end
    end

    assign rts_o = r_rts;

    // ------------------------------------------------------------------
    // TX frame FSM
    // ------------------------------------------------------------------
    uart_state_t       r_tx_state;
    logic [DIV_W-1:0]  r_tx_cnt;
    logic [DIV_W-1:0]  r_tx_div;
    logic [3:0]        r_tx_bit;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_tx_par_en;
    logic              r_tx_par_bit;
    logic              r_tx_stop2;
    logic              r_tx_stop_second;
    logic              r_txd;
    logic              w_tx_bit_end;
    logic              w_tx_frame_end;

    assign w_tx_bit_end   = (r_tx_cnt == '0);
    assign w_tx_frame_end = (r_tx_state == ST_STOP) & w_tx_bit_end &
                            (~r_tx_stop2 | r_tx_stop_second);
    // A new frame may start from IDLE or directly at the end of the last stop
    // bit, which gives back-to-back frames with no idle bit in between.
    assign w_tx_launch    = tx_en_i & ~w_tx_empty & w_cts_ok &
                            ((r_tx_state == ST_IDLE) | w_tx_frame_end);

    // TX sequencing: START, DATA (LSB first), optional PARITY, 1 or 2 STOP bits.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_tx_state       <= ST_IDLE;
            r_tx_cnt         <= '0;
            r_tx_div         <= '0;
            r_tx_bit         <= '0;
            r_tx_shift       <= '0;
            r_tx_par_en      <= 1'b0;
            r_tx_par_bit     <= 1'b0;
            r_tx_stop2       <= 1'b0;
            r_tx_stop_second <= 1'b0;
            r_txd            <= 1'b1;
        end else if (cke_i) begin
            if (w_tx_launch) begin
                // Frame format is captured here so mid-frame changes wait a frame.
                r_tx_state       <= ST_START;
                r_tx_div         <= div_i;
                r_tx_cnt         <= div_i - 1'b1;
                r_tx_shift       <= w_tx_head;
                r_tx_par_en      <= parity_enabled(parity_i);
                r_tx_par_bit     <= parity_bit(8'(w_tx_head), parity_i);
                r_tx_stop2       <= stop2_i;
                r_tx_stop_second <= 1'b0;
                r_txd            <= 1'b0;
            end else begin
                case (r_tx_state)
                    ST_IDLE: begin
                        r_txd <= 1'b1;
                    end
                    ST_START: begin
                        if (w_tx_bit_end) begin
                            r_tx_state <= ST_DATA;
                            r_tx_cnt   <= r_tx_div - 1'b1;
                            r_tx_bit   <= '0;
                            r_txd      <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (w_tx_bit_end) begin
                            r_tx_cnt <= r_tx_div - 1'b1;
                            if (r_tx_bit == LAST_BIT) begin
                                if (r_tx_par_en) begin
                                    r_tx_state <= ST_PARITY;
                                    r_txd      <= r_tx_par_bit;
                                end else begin
                                    r_tx_state <= ST_STOP;
                                    r_txd      <= 1'b1;
                                end
                            end else begin
                                r_tx_bit   <= r_tx_bit + 1'b1;
                                r_txd      <= r_tx_shift[0];
                                r_tx_shift <= r_tx_shift >> 1;
                            end
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (w_tx_bit_end) begin
                            r_tx_state <= ST_STOP;
                            r_tx_cnt   <= r_tx_div - 1'b1;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (w_tx_bit_end) begin
                            if (r_tx_stop2 && !r_tx_stop_second) begin
                                r_tx_stop_second <= 1'b1;
                                r_tx_cnt         <= r_tx_div - 1'b1;
                            end else begin
                                r_tx_state <= ST_IDLE;
                            end
                            r_txd <= 1'b1;
                        end else begin
                            r_tx_cnt <= r_tx_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_tx_state <= ST_IDLE;
                        r_txd      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign txd_o     = r_txd;
    assign tx_idle_o = w_tx_empty & (r_tx_state == ST_IDLE);

    // ------------------------------------------------------------------
    // RX synchroniser and frame FSM
    // ------------------------------------------------------------------
    logic             r_rxd_s1;
    logic             r_rxd_s2;
    logic             r_rxd_prev;
    uart_state_t      r_rx_state;
    logic [DIV_W-1:0] r_rx_cnt;
    logic [DIV_W-1:0] r_rx_div;
    logic [3:0]       r_rx_bit;
    logic [1:0]       r_rx_par_mode;
    logic             r_rx_par_err;
    logic             w_rx_fall;
    logic             w_rx_bit_end;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_rxd_s1   <= 1'b1;
            r_rxd_s2   <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else if (cke_i) begin
            r_rxd_s1   <= rxd_i;
            r_rxd_s2   <= r_rxd_s1;
            r_rxd_prev <= r_rxd_s2;
        end
    end

    assign w_rx_fall    = r_rxd_prev & ~r_rxd_s2;
    assign w_rx_bit_end = (r_rx_cnt == '0);
    assign w_rx_done    = (r_rx_state == ST_STOP) & w_rx_bit_end;

    // RX sequencing: start bit re-checked at half a bit, then mid-bit sampling.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_rx_state    <= ST_IDLE;
            r_rx_cnt      <= '0;
            r_rx_div      <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_rx_par_mode <= '0;
            r_rx_par_err  <= 1'b0;
        end else if (cke_i) begin
            case (r_rx_state)
                ST_IDLE: begin
                    if (rx_en_i && w_rx_fall) begin
                        r_rx_state    <= ST_START;
                        r_rx_div      <= div_i;
                        r_rx_cnt      <= (div_i >> 1) - 1'b1;
                        r_rx_par_mode <= parity_i;
                        r_rx_par_err  <= 1'b0;
                        r_rx_bit      <= '0;
                    end
                end
                ST_START: begin
                    if (w_rx_bit_end) begin
                        // A line already back high is a glitch, not a start bit.
                        r_rx_state <= r_rxd_s2 ? ST_IDLE : ST_DATA;
                        r_rx_cnt   <= r_rx_div - 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_shift <= {r_rxd_s2, r_rx_shift[DATA_W-1:1]};
                        r_rx_cnt   <= r_rx_div - 1'b1;
                        if (r_rx_bit == LAST_BIT) begin
                            r_rx_state <= parity_enabled(r_rx_par_mode) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_rx_bit_end) begin
                        r_rx_par_err <= (r_rxd_s2 != parity_bit(8'(r_rx_shift), r_rx_par_mode));
                        r_rx_state   <= ST_STOP;
                        r_rx_cnt     <= r_rx_div - 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    // Only the first stop bit is checked; a second one is plain idle.
                    if (w_rx_bit_end) begin
                        r_rx_state <= ST_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                default: begin
                    r_rx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic [2:0] w_err_new;
    logic [2:0] r_err;

    // Error events are raised on the cycle the frame completes.
    always_comb begin
        w_err_new              = '0;
        w_err_new[ERR_OVERRUN] = w_rx_done & w_rx_full & ~rx_ready_i;
        w_err_new[ERR_FRAME]   = w_rx_done & ~r_rxd_s2;
        w_err_new[ERR_PARITY]  = w_rx_done & r_rx_par_err;
    end

    // Clearing loses to a new event arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (w_rst) begin
            r_err <= '0;
        end else if (cke_i) begin
            r_err <= (err_clr_i ? 3'b000 : r_err) | w_err_new;
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_iob_uart_fifo_core.sv
// Self-checking bench for iob_uart_fifo_core: TX waveform, loopback with a
// scoreboard, RX overrun/frame/parity errors, glitch rejection, soft reset and
// (when IOB_UART_FLOW_CTRL_EN is defined) cts/rts flow control.
module tb_iob_uart_fifo_core;

`ifdef IOB_UART_FLOW_CTRL_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cke_i = 1'b1;
    logic       soft_rst_i = 1'b0;
    logic       tx_en_i = 1'b0;
    logic       rx_en_i = 1'b1;
    logic [15:0] div_i = 16'd16;
    logic [1:0] parity_i = 2'b00;
    logic       stop2_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic       tx_idle_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i = 1'b0;
    logic [4:0] tx_level_o;
    logic [4:0] rx_level_o;
    logic [2:0] err_o;
    logic       err_clr_i = 1'b0;
    logic       txd_o;
    logic       cts_i = 1'b1;
    logic       rts_o;
    logic       tb_rxd = 1'b1;
    logic       loop_en = 1'b0;
    logic       w_rxd;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    assign w_rxd = loop_en ? txd_o : tb_rxd;

    always #5 clk = ~clk;

    iob_uart_fifo_core dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cke_i      (cke_i),
        .soft_rst_i (soft_rst_i),
        .tx_en_i    (tx_en_i),
        .rx_en_i    (rx_en_i),
        .div_i      (div_i),
        .parity_i   (parity_i),
        .stop2_i    (stop2_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .tx_idle_o  (tx_idle_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .tx_level_o (tx_level_o),
        .rx_level_o (rx_level_o),
        .err_o      (err_o),
        .err_clr_i  (err_clr_i),
        .rxd_i      (w_rxd),
        .txd_o      (txd_o),
        .cts_i      (cts_i),
        .rts_o      (rts_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push one byte into the TX FIFO; optionally expect it back on RX.
    task automatic push_tx(input logic [7:0] d, input bit expect_rx);
        int n = 0;
        while (!tx_ready_o && n < 5000) begin
            tick(1);
            n++;
        end
        if (!tx_ready_o) begin
            check_eq("tx_ready_timeout", 32'(tx_ready_o), 32'd1);
        end else begin
            tx_data_i  = d;
            tx_valid_i = 1'b1;
            if (expect_rx) exp_q.push_back(d);
            tick(1);
            tx_valid_i = 1'b0;
            $display("tx push %02h", d);
        end
    endtask

    // Drive one 8-bit frame on rxd at 16 clk per bit, then 16 clk idle.
    task automatic send_rx(input logic [7:0] d, input logic [1:0] par,
                           input logic flip, input logic stop_v);
        tb_rxd = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            tb_rxd = d[i];
            tick(16);
        end
        if (par == 2'b01 || par == 2'b10) begin
            tb_rxd = ((par == 2'b10) ? ~(^d) : (^d)) ^ flip;
            tick(16);
        end
        tb_rxd = stop_v;
        tick(16);
        tb_rxd = 1'b1;
        tick(16);
        $display("rx line frame %02h par %0d flip %0d stop %0d", d, par, flip, stop_v);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || rx_valid_o) && n < bound) begin
            tick(1);
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        tick(1);
        err_clr_i = 1'b0;
        check_eq("err_clr", 32'(err_o), 32'd0);
    endtask

    // Scoreboard: every accepted RX pop is compared against the expected queue.
    always @(negedge clk) begin
        if (rx_valid_o && rx_ready_i && cke_i) begin
            if (exp_q.size() == 0) begin
                check_eq("rx_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check_eq("rx_data", 32'(rx_data_o), 32'(e));
                $display("rx pop %02h expected %02h", rx_data_o, e);
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic [9:0] frame;

        // Reset state
        tick(3);
        check_eq("rst_txd", 32'(txd_o), 32'd1);
        check_eq("rst_rts", 32'(rts_o), 32'd0);
        check_eq("rst_err", 32'(err_o), 32'd0);
        check_eq("rst_tx_ready", 32'(tx_ready_o), 32'd1);
        check_eq("rst_rx_valid", 32'(rx_valid_o), 32'd0);
        check_eq("rst_tx_idle", 32'(tx_idle_o), 32'd1);
        rst_i = 1'b0;
        tick(2);
        check_eq("rts_follow_en", 32'(rts_o), 32'd1);

        // 1. div=16, 8N1, 0xA5 waveform
        tx_en_i = 1'b1;
        d = 8'hA5;
        frame = {1'b1, d, 1'b0};
        push_tx(d, 1'b0);
        tick(1);
        check_eq("tx_first_start", 32'(txd_o), 32'd0);
        check_eq("tx_busy", 32'(tx_idle_o), 32'd0);
        tick(8);
        for (int i = 0; i < 10; i++) begin
            check_eq("tx_bit", 32'(txd_o), 32'(frame[i]));
            tick(16);
        end
        check_eq("tx_idle_after", 32'(tx_idle_o), 32'd1);

`ifdef IOB_UART_FLOW_CTRL_EN
        // 6a. cts gating
        cts_i = 1'b0;
        tick(4);
        push_tx(8'h11, 1'b0);
        push_tx(8'h22, 1'b0);
        tick(100);
        check_eq("cts_hold_txd", 32'(txd_o), 32'd1);
        check_eq("cts_hold_level", 32'(tx_level_o), 32'd2);
        cts_i = 1'b1;
        tick(10);
        check_eq("cts_go_txd", 32'(txd_o), 32'd0);
        tick(400);
        check_eq("cts_done", 32'(tx_idle_o), 32'd1);
`endif

        // 2. Loopback 8E2, 32 bytes through 16-deep FIFOs
        parity_i   = 2'b01;
        stop2_i    = 1'b1;
        tx_en_i    = 1'b0;
        loop_en    = 1'b1;
        rx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) push_tx(8'(i), 1'b1);
        check_eq("tx_full_level", 32'(tx_level_o), 32'd16);
        check_eq("tx_full_ready", 32'(tx_ready_o), 32'd0);
        tx_en_i = 1'b1;
        for (int i = 16; i < 32; i++) push_tx(8'(i), 1'b1);
        wait_drain(12000);
        check_eq("loop_err", 32'(err_o), 32'd0);
        tick(200);
        check_eq("loop_tx_idle", 32'(tx_idle_o), 32'd1);
        loop_en = 1'b0;
        tx_en_i = 1'b0;

        // 3. RX overrun
        parity_i   = 2'b00;
        stop2_i    = 1'b0;
        rx_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_rx(8'h80 + 8'(i), 2'b00, 1'b0, 1'b1);
            exp_q.push_back(8'h80 + 8'(i));
            if (i == 12) check_eq("rts_13", 32'(rts_o), 32'd1);
            if (i == 13) check_eq("rts_14", 32'(rts_o), FLOW ? 32'd0 : 32'd1);
        end
        check_eq("rx_full_level", 32'(rx_level_o), 32'd16);
        check_eq("rx_full_err", 32'(err_o), 32'd0);
        send_rx(8'h55, 2'b00, 1'b0, 1'b1);
        check_eq("ovr_err", 32'(err_o), 32'b100);
        check_eq("ovr_level", 32'(rx_level_o), 32'd16);
        check_eq("ovr_head", 32'(rx_data_o), 32'h80);
        clear_err();
        rx_ready_i = 1'b1;
        wait_drain(200);

        // 4. Frame error and parity error, data still delivered
        exp_q.push_back(8'h3C);
        send_rx(8'h3C, 2'b00, 1'b0, 1'b0);
        wait_drain(200);
        check_eq("frame_err", 32'(err_o), 32'b010);
        clear_err();
        parity_i = 2'b10;
        exp_q.push_back(8'h3C);
        send_rx(8'h3C, 2'b10, 1'b1, 1'b1);
        wait_drain(200);
        check_eq("parity_err", 32'(err_o), 32'b001);
        clear_err();
        exp_q.push_back(8'h5B);
        send_rx(8'h5B, 2'b10, 1'b0, 1'b1);
        wait_drain(200);
        check_eq("parity_ok", 32'(err_o), 32'd0);
        parity_i = 2'b00;

        // 5. Glitch rejection
        tb_rxd = 1'b0;
        tick(3);
        tb_rxd = 1'b1;
        tick(40);
        check_eq("glitch_level", 32'(rx_level_o), 32'd0);
        check_eq("glitch_err", 32'(err_o), 32'd0);
        exp_q.push_back(8'hC3);
        send_rx(8'hC3, 2'b00, 1'b0, 1'b1);
        wait_drain(200);

        // 5b. Soft reset mid-frame
        tx_en_i = 1'b1;
        push_tx(8'h0F, 1'b0);
        push_tx(8'hF0, 1'b0);
        push_tx(8'h33, 1'b0);
        check_eq("pre_srst_txd", 32'(txd_o), 32'd0);
        check_eq("pre_srst_level", 32'(tx_level_o), 32'd2);
        tx_en_i    = 1'b0;
        soft_rst_i = 1'b1;
        tick(1);
        soft_rst_i = 1'b0;
        check_eq("srst_txd", 32'(txd_o), 32'd1);
        check_eq("srst_tx_level", 32'(tx_level_o), 32'd0);
        check_eq("srst_rx_level", 32'(rx_level_o), 32'd0);
        check_eq("srst_idle", 32'(tx_idle_o), 32'd1);
        rx_en_i = 1'b0;
        tick(2);
        check_eq("rts_off", 32'(rts_o), 32'd0);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
